fetch_queue_unit: RTL and testbench

//   IF-stage fetch engine; consumes the pipeline controller's stall (if_we), flush and PC-select (m4_1_cnt).

---
 rtl/fetch_queue_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// IF-stage fetch engine: PC generation, in-order variable-latency imem requests,
// a DEPTH-entry instruction queue feeding IF/ID, and flush-driven redirect/discard.
module fetch_queue_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_we,
   input  logic            flush,
   input  logic [1:0]      m4_1_cnt,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_DRAIN = 2'b10;

   localparam logic [AW+1:0] DEPTH_O = (AW+2)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW:0]     infl_q, infl_d;
   logic [AW:0]     disc_q, disc_d;
   logic [AW-1:0]   q_wp_q, q_wp_d, q_rp_q, q_rp_d;
   logic [AW-1:0]   t_wp_q, t_wp_d, t_rp_q, t_rp_d;

   logic [XLEN-1:0] q_inst_q [DEPTH];
   logic [XLEN-1:0] q_pc_q   [DEPTH];
   logic [XLEN-1:0] t_pc_q   [DEPTH];

   logic [AW+1:0]   occ;
   logic            issue, push, pop;
   logic [XLEN-1:0] jalr_al;

   assign occ     = {1'b0, cnt_q} + {1'b0, infl_q};
   assign issue   = (state_q == S_FETCH) && (occ < DEPTH_O) && !flush;
   // Responses still owed to a squashed path are dropped; so is one landing on a flush.
   assign push    = imem_rvalid && (disc_q == '0) && !flush;
   assign pop     = (cnt_q != '0) && if_we && !flush;
   assign jalr_al = jalr_target & ~XLEN'(1);

   assign imem_req   = issue;
   assign imem_addr  = pc_q;
   assign inst_valid = (cnt_q != '0);
   assign inst       = q_inst_q[q_rp_q];
   assign inst_pc    = q_pc_q[q_rp_q];

   always_comb begin
      pc_d = pc_q;
      if (flush) begin
         case (m4_1_cnt)
            2'b01:   pc_d = branch_target;
            2'b10:   pc_d = jalr_al;
            default: pc_d = pc_q + PC_INC;
         endcase
      end else if (issue) begin
         pc_d = pc_q + PC_INC;
      end
   end

   always_comb begin
      infl_d = infl_q;
      if (issue && !imem_rvalid)      infl_d = infl_q + CNT_ONE;
      else if (!issue && imem_rvalid) infl_d = infl_q - CNT_ONE;
   end

   // Everything still in flight after this cycle's response belongs to the old path.
   always_comb begin
      disc_d = disc_q;
      if (flush)                            disc_d = imem_rvalid ? infl_q - CNT_ONE : infl_q;
      else if (imem_rvalid && disc_q != '0) disc_d = disc_q - CNT_ONE;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         default: state_d = (disc_d != '0) ? S_DRAIN : S_FETCH;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (flush) cnt_d = '0;
      else begin
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_comb begin
      q_wp_d = q_wp_q;
      q_rp_d = q_rp_q;
      t_wp_d = t_wp_q;
      t_rp_d = t_rp_q;
      if (flush) begin
         q_wp_d = '0;
         q_rp_d = '0;
         t_wp_d = '0;
         t_rp_d = '0;
      end else begin
         if (push)  q_wp_d = q_wp_q + PTR_ONE;
         if (pop)   q_rp_d = q_rp_q + PTR_ONE;
         if (issue) t_wp_d = t_wp_q + PTR_ONE;
         if (push)  t_rp_d = t_rp_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         infl_q  <= '0;
         disc_q  <= '0;
         q_wp_q  <= '0;
         q_rp_q  <= '0;
         t_wp_q  <= '0;
         t_rp_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst_q[i] <= '0;
            q_pc_q[i]   <= '0;
            t_pc_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         infl_q  <= infl_d;
         disc_q  <= disc_d;
         q_wp_q  <= q_wp_d;
         q_rp_q  <= q_rp_d;
         t_wp_q  <= t_wp_d;
         t_rp_q  <= t_rp_d;
         if (push) begin
            q_inst_q[q_wp_q] <= imem_rdata;
            q_pc_q[q_wp_q]   <= t_pc_q[t_rp_q];
         end
         if (issue) t_pc_q[t_wp_q] <= pc_q;
      end
   end

   a_no_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && infl_q == '0));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop && cnt_q == '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: in-order variable-latency imem model plus a
// request/queue-level reference model checked every cycle, with literal spot checks.
module tb_fetch_queue_unit;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [15:0] WE_PAT   = 16'b1011_0011_1110_0101;

   logic        clk = 1'b0;
   logic        rst, if_we, flush, imem_rvalid, imem_req, inst_valid;
   logic [1:0]  m4_1_cnt;
   logic [31:0] branch_target, jalr_target, imem_addr, imem_rdata, inst, inst_pc;

   always #5 clk = ~clk;

   fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .if_we(if_we), .flush(flush), .m4_1_cnt(m4_1_cnt),
      .branch_target(branch_target), .jalr_target(jalr_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
   );

   typedef struct { logic [31:0] pc; bit keep; } pend_t;
   typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
   typedef struct { int rdy; logic [31:0] addr; } mreq_t;

   pend_t       mp[$];      // model: outstanding requests, keep=0 once squashed
   ent_t        mq[$];      // model: instruction queue
   mreq_t       mem[$];     // imem: requests awaiting a response
   logic [31:0] m_pc;
   bit          m_started;
   logic [31:0] addr_log[$], pc_log[$];
   int          cyc, last_rdy, first_valid, rel0;
   bit          rel_armed;
   int          errors, checks;
   bit          s_rst, s_we, s_fl, s_varlat;
   logic [1:0]  s_sel;
   logic [31:0] s_bt, s_jt;
   int          lat;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h5A5A_F00D;
   endfunction

   function automatic bit m_draining();
      foreach (mp[i]) if (!mp[i].keep) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_req();
      return m_started && !m_draining() && (mq.size() + mp.size() < DEPTH) && !s_fl;
   endfunction

   function automatic logic [31:0] al(input int i);
      return (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pl(input int i);
      return (i < pc_log.size()) ? pc_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      pend_t e;
      mreq_t r;
      bit    issue, can_pop;
      int    l;
      @(negedge clk);
      rst = s_rst; if_we = s_we; flush = s_fl; m4_1_cnt = s_sel;
      branch_target = s_bt; jalr_target = s_jt;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      if (s_rst) begin
         mem.delete(); last_rdy = 0;
      end else if (mem.size() > 0 && mem[0].rdy <= cyc) begin
         r = mem.pop_front();
         imem_rvalid = 1'b1; imem_rdata = mem_f(r.addr);
      end
      #1;
      if (s_rst) begin
         rel_armed = 1'b1; first_valid = -1;
      end else begin
         if (rel_armed) begin rel0 = cyc; rel_armed = 1'b0; end
         issue = m_req();
         chk("imem_req", imem_req, issue);
         if (issue) chk("imem_addr", imem_addr, m_pc);
         chk("inst_valid", inst_valid, mq.size() > 0);
         if (mq.size() > 0) begin
            chk("inst", inst, mq[0].ins);
            chk("inst_pc", inst_pc, mq[0].pc);
         end
         if (inst_valid && first_valid < 0) first_valid = cyc;
         if (imem_req) begin
            addr_log.push_back(imem_addr);
            l = s_varlat ? 1 + (cyc % 3) : lat;
            r.rdy = (cyc + l > last_rdy) ? cyc + l : last_rdy + 1;
            r.addr = imem_addr;
            last_rdy = r.rdy;
            mem.push_back(r);
         end
         if (inst_valid && if_we && !flush) pc_log.push_back(inst_pc);
      end
      // reference model advances to the next cycle
      if (s_rst) begin
         mp.delete(); mq.delete(); m_pc = RESET_PC; m_started = 1'b0;
      end else begin
         issue = m_req();
         can_pop = mq.size() > 0;
         if (can_pop && s_we && !s_fl) void'(mq.pop_front());
         if (imem_rvalid && mp.size() > 0) begin
            e = mp.pop_front();
            if (e.keep && !s_fl) mq.push_back('{ins: mem_f(e.pc), pc: e.pc});
         end
         if (issue) begin
            mp.push_back('{pc: m_pc, keep: 1'b1});
            m_pc = m_pc + 32'd4;
         end
         if (s_fl) begin
            mq.delete();
            foreach (mp[i]) mp[i].keep = 1'b0;
            case (s_sel)
               2'b01:   m_pc = s_bt;
               2'b10:   m_pc = {s_jt[31:1], 1'b0};
               default: m_pc = m_pc + 32'd4;
            endcase
         end
         m_started = 1'b1;
      end
      cyc++;
   endtask

   task automatic do_flush(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] jt);
      s_fl = 1'b1; s_sel = sel; s_bt = bt; s_jt = jt;
      step();
      // targets/select left at junk values: they must be ignored without flush
      s_fl = 1'b0; s_sel = 2'b10; s_bt = 32'hBAD0_0000; s_jt = 32'hBAD0_0001;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_imem_req"}, imem_req, 1'b0);
      chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
      chk({tag, "_inst_valid"}, inst_valid, 1'b0);
      chk({tag, "_inst"}, inst, 32'h0);
      chk({tag, "_inst_pc"}, inst_pc, 32'h0);
   endtask

   task automatic clear_logs();
      addr_log.delete(); pc_log.delete();
   endtask

   initial begin
      rst = 1'b1; if_we = 1'b1; flush = 1'b0; m4_1_cnt = 2'b00;
      branch_target = 32'h0; jalr_target = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      s_rst = 1'b1; s_we = 1'b1; s_fl = 1'b0; s_sel = 2'b00; s_bt = 32'h0; s_jt = 32'h0;
      lat = 1; s_varlat = 1'b0; cyc = 0; last_rdy = 0; first_valid = -1; rel0 = 0;
      rel_armed = 1'b0; errors = 0; checks = 0; m_pc = RESET_PC; m_started = 1'b0;

      repeat (2) step();
      s_rst = 1'b0;
      step();
      reset_checks("reset");

      // sequential fetch at latency 1, then a 5-cycle stall holding pc 0x8
      for (int i = 0; i < 20 && pc_log.size() < 2; i++) step();
      chk("t2_pops_before_stall", pc_log.size(), 2);
      s_we = 1'b0;
      repeat (5) step();
      chk("t2_hold_valid", inst_valid, 1'b1);
      chk("t2_hold_pc", inst_pc, 32'h8);
      chk("t2_no_pop_in_stall", pc_log.size(), 2);
      s_we = 1'b1;
      repeat (12) step();
      chk("t1_addr0", al(0), 32'h0);
      chk("t1_addr1", al(1), 32'h4);
      chk("t1_addr2", al(2), 32'h8);
      chk("t1_first_valid_cycle", first_valid - rel0, 3);
      for (int i = 0; i < 5; i++) chk("t2_pc_order", pl(i), 32'(4 * i));

      // variable latency with an irregular consume pattern
      s_varlat = 1'b1;
      for (int i = 0; i < 16; i++) begin s_we = WE_PAT[i]; step(); end
      s_we = 1'b1; s_varlat = 1'b0;

      // branch flush with two requests in flight
      lat = 4;
      for (int i = 0; i < 40 && !(mem.size() == 2 && mem[0].rdy > cyc); i++) step();
      chk("t3_two_inflight", mem.size(), 2);
      clear_logs();
      do_flush(2'b01, 32'h100, 32'h0);
      repeat (16) step();
      chk("t3_first_addr", al(0), 32'h100);
      chk("t3_first_pc", pl(0), 32'h100);

      // second flush while still draining re-latches the target
      for (int i = 0; i < 40 && !(mem.size() == 2 && mem[0].rdy > cyc); i++) step();
      chk("t3b_two_inflight", mem.size(), 2);
      clear_logs();
      do_flush(2'b01, 32'h400, 32'h0);
      step();
      do_flush(2'b01, 32'h480, 32'h0);
      repeat (16) step();
      chk("t3b_first_addr", al(0), 32'h480);
      chk("t3b_first_pc", pl(0), 32'h480);

      // jalr flush coinciding with a response
      lat = 1;
      for (int i = 0; i < 20 && !(mem.size() > 0 && mem[0].rdy <= cyc); i++) step();
      chk("t4_rsp_due", (mem.size() > 0 && mem[0].rdy <= cyc), 1'b1);
      clear_logs();
      do_flush(2'b10, 32'h0, 32'h203);
      repeat (10) step();
      chk("t4_first_addr", al(0), 32'h202);
      chk("t4_first_pc", pl(0), 32'h202);
      chk("t4_second_pc", pl(1), 32'h206);

      // reserved select behaves as pc+4
      do_flush(2'b11, 32'hDEAD_0000, 32'hBEEF_0001);
      repeat (8) step();

      // address wrap
      clear_logs();
      do_flush(2'b01, 32'hFFFF_FFF8, 32'h0);
      repeat (12) step();
      chk("t5_addr0", al(0), 32'hFFFF_FFF8);
      chk("t5_addr1", al(1), 32'hFFFF_FFFC);
      chk("t5_addr2", al(2), 32'h0);
      chk("t5_pc2", pl(2), 32'h0);

      // reset in the middle of a drain
      lat = 5;
      for (int i = 0; i < 20 && mem.size() == 0; i++) step();
      chk("t6_inflight", mem.size() > 0, 1'b1);
      do_flush(2'b01, 32'h300, 32'h0);
      step();
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      clear_logs();
      step();
      reset_checks("t6_reset");
      repeat (12) step();
      chk("t6_first_addr", al(0), RESET_PC);
      chk("t6_second_addr", al(1), RESET_PC + 32'd4);
      chk("t6_first_pc", pl(0), RESET_PC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
